// File: rtl/ls299.sv
// ls299: clk-domain model of an 8-bit universal shift/storage register with
// a shared three-state I/O bus. The chip clock pin is sampled and edge-detected
// on the system clock rather than used as a clock itself.
module ls299 (
   input  logic       clk,
   input  logic       reset,
   input  logic       cp,
   input  logic       n_mr,
   input  logic       s0,
   input  logic       s1,
   input  logic       n_oe1,
   input  logic       n_oe2,
   input  logic       ds0,
   input  logic       ds7,
   input  logic [7:0] io_in,
   output logic [7:0] io_out,
   output logic       io_oe,
   output logic       q0,
   output logic       q7
);

   logic [7:0] data_r;
   logic [7:0] data_nxt_s;
   logic       cp_prev_r;
   logic       cpe_s;

   // Rising edge of the sampled chip clock pin.
   assign cpe_s = cp & ~cp_prev_r;

   // Next register value: master clear has priority, then the mode selected on a chip clock edge.
   always_comb begin
      data_nxt_s = data_r;
      if (!n_mr) begin
         data_nxt_s = 8'h00;
      end else if (cpe_s) begin
         case ({s1, s0})
            2'b00:   data_nxt_s = data_r;
            2'b01:   data_nxt_s = {data_r[6:0], ds0};
            2'b10:   data_nxt_s = {ds7, data_r[7:1]};
            2'b11:   data_nxt_s = io_in;
            default: data_nxt_s = data_r;
         endcase
      end else begin
         data_nxt_s = data_r;
      end
   end

   // State registers; cp_prev resets high so a cp already high at release is not an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_r    <= 8'h00;
         cp_prev_r <= 1'b1;
      end else begin
         data_r    <= data_nxt_s;
         cp_prev_r <= cp;
      end
   end

   // Bus drive: both enables low and not in parallel-load mode (which listens to the bus).
   always_comb begin
      io_oe  = ~n_oe1 & ~n_oe2 & ~(s0 & s1);
      io_out = 8'hFF;
      if (io_oe) begin
         io_out = data_r;
      end else begin
         io_out = 8'hFF;
      end
   end

   // Serial outputs always reflect the end bits of the register.
   assign q0 = data_r[0];
   assign q7 = data_r[7];

endmodule

// File: tb/tb_ls299.sv
// Self-checking bench for ls299: directed scenarios followed by random
// stimulus, compared against a behavioural model of the chip's rules.
module tb_ls299;

   logic       clk;
   logic       reset;
   logic       cp;
   logic       n_mr;
   logic       s0;
   logic       s1;
   logic       n_oe1;
   logic       n_oe2;
   logic       ds0;
   logic       ds7;
   logic [7:0] io_in;
   logic [7:0] io_out;
   logic       io_oe;
   logic       q0;
   logic       q7;

   int total;
   int bad;

   // behavioural model state
   int m_val;
   bit m_cp_seen;

   ls299 dut (
      .clk(clk), .reset(reset), .cp(cp), .n_mr(n_mr), .s0(s0), .s1(s1),
      .n_oe1(n_oe1), .n_oe2(n_oe2), .ds0(ds0), .ds7(ds7), .io_in(io_in),
      .io_out(io_out), .io_oe(io_oe), .q0(q0), .q7(q7)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare every output against what the model says the pins should show.
   task automatic check_all(input string tag);
      bit       oe;
      bit [7:0] v;
      v  = m_val[7:0];
      oe = !n_oe1 && !n_oe2 && !(s0 && s1);
      chk({tag, ".oe"}, {7'b0, io_oe}, {7'b0, oe});
      chk({tag, ".out"}, io_out, oe ? v : 8'hFF);
      chk({tag, ".q0"}, {7'b0, q0}, {7'b0, v[0]});
      chk({tag, ".q7"}, {7'b0, q7}, {7'b0, v[7]});
   endtask

   // One system clock: apply the chip's rules to the inputs present at the edge.
   task automatic tick(input string tag);
      @(posedge clk);
      if (reset) begin
         m_val     = 0;
         m_cp_seen = 1'b1;
      end else begin
         if (!n_mr) begin
            m_val = 0;
         end else if (cp && !m_cp_seen) begin
            if (!s1 && s0)      m_val = (m_val * 2 + int'(ds0)) % 256;
            else if (s1 && !s0) m_val = m_val / 2 + 128 * int'(ds7);
            else if (s1 && s0)  m_val = int'(io_in);
         end
         m_cp_seen = cp;
      end
      #1;
      check_all(tag);
   endtask

   task automatic pulse(input string tag);
      cp = 1'b1;
      tick(tag);
      cp = 1'b0;
      tick(tag);
   endtask

   task automatic load(input logic [7:0] v);
      s1 = 1'b1; s0 = 1'b1; io_in = v;
      pulse("load");
      s1 = 1'b0; s0 = 1'b0;
   endtask

   task automatic async_reset(input string tag);
      reset     = 1'b1;
      m_val     = 0;
      m_cp_seen = 1'b1;
      #1;
      check_all(tag);
      tick(tag);
      reset = 1'b0;
   endtask

   initial begin
      total = 0; bad = 0;
      m_val = 0; m_cp_seen = 1'b1;
      reset = 1'b1; cp = 1'b0; n_mr = 1'b1; s0 = 1'b0; s1 = 1'b0;
      n_oe1 = 1'b0; n_oe2 = 1'b0; ds0 = 1'b0; ds7 = 1'b0; io_in = 8'h00;
      tick("por");
      tick("por");
      chk("por_out", io_out, 8'h00);
      reset = 1'b0;
      tick("idle");

      // parallel load releases the bus, then drives it in hold mode
      s1 = 1'b1; s0 = 1'b1; io_in = 8'hA5; cp = 1'b1;
      tick("ld");
      chk("ld_oe", {7'b0, io_oe}, 8'h00);
      chk("ld_out", io_out, 8'hFF);
      cp = 1'b0; s1 = 1'b0; s0 = 1'b0;
      tick("ld_hold");
      chk("ld_drive", io_out, 8'hA5);

      // shift right
      load(8'h81);
      s1 = 1'b0; s0 = 1'b1; ds0 = 1'b0;
      pulse("sr1");
      chk("sr1_val", io_out, 8'h02);
      ds0 = 1'b1;
      pulse("sr2");
      chk("sr2_val", io_out, 8'h05);

      // shift left
      load(8'h81);
      s1 = 1'b1; s0 = 1'b0; ds7 = 1'b1;
      pulse("sl");
      chk("sl_val", io_out, 8'hC0);
      chk("sl_q7", {7'b0, q7}, 8'h01);

      // clear beats a coincident load; held cp after release gives no edge
      load(8'hFF);
      s1 = 1'b1; s0 = 1'b1; io_in = 8'h3C; n_mr = 1'b0; cp = 1'b1;
      tick("clr");
      n_mr = 1'b1;
      for (int i = 0; i < 10; i++) tick("clr_hold");
      s1 = 1'b0; s0 = 1'b0;
      tick("clr_chk");
      chk("clr_val", io_out, 8'h00);
      cp = 1'b0;
      tick("clr_end");

      // output enables
      load(8'h5A);
      n_oe1 = 1'b1; tick("oe1");
      chk("oe1_out", io_out, 8'hFF);
      n_oe1 = 1'b0; n_oe2 = 1'b1; tick("oe2");
      chk("oe2_out", io_out, 8'hFF);
      n_oe2 = 1'b0; tick("oe_both");
      chk("oe_on", io_out, 8'h5A);

      // async reset with cp held high: no update until a fresh rise
      s1 = 1'b1; s0 = 1'b1; io_in = 8'h77; cp = 1'b1;
      tick("r77");
      s1 = 1'b0; s0 = 1'b0;
      tick("r77h");
      chk("r77_val", io_out, 8'h77);
      async_reset("arst");
      chk("arst_val", io_out, 8'h00);
      s1 = 1'b1; s0 = 1'b1; io_in = 8'h99;
      for (int i = 0; i < 3; i++) tick("arst_hold");
      s1 = 1'b0; s0 = 1'b0;
      tick("arst_chk");
      chk("arst_noupd", io_out, 8'h00);
      s1 = 1'b1; s0 = 1'b1; cp = 1'b0;
      tick("arst_low");
      cp = 1'b1;
      tick("arst_rise");
      s1 = 1'b0; s0 = 1'b0; cp = 1'b0;
      tick("arst_after");
      chk("arst_upd", io_out, 8'h99);

      // random stimulus against the model
      for (int i = 0; i < 600; i++) begin
         cp    = 1'($urandom_range(0, 1));
         s0    = 1'($urandom_range(0, 1));
         s1    = 1'($urandom_range(0, 1));
         ds0   = 1'($urandom_range(0, 1));
         ds7   = 1'($urandom_range(0, 1));
         io_in = 8'($urandom);
         n_mr  = ($urandom_range(0, 15) != 0);
         n_oe1 = ($urandom_range(0, 5) == 0);
         n_oe2 = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 49) == 0) begin
            async_reset("rnd_rst");
         end else begin
            tick("rnd");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ls299.md
LS299 -- requirements
Module: ls299

Interface
REQ-001 clk  input  1  system clock; all internal state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clears all internal state.
REQ-003 cp  input  1  chip clock pin level (pin 12), sampled on clk; never used as a clock.
REQ-004 n_mr  input  1  chip master reset (pin 9), active-low, sampled on clk.
REQ-005 s0, s1  input  1 each  mode select (pins 1, 19).
REQ-006 n_oe1, n_oe2  input  1 each  output enables (pins 2, 3), active-low.
REQ-007 ds0  input  1  serial data in for shift right, enters bit 0 (pin 11).
REQ-008 ds7  input  1  serial data in for shift left, enters bit 7 (pin 18).
REQ-009 io_in  input  8  I/O pin levels seen from the bus, parallel-load source.
REQ-010 io_out  output  8  register contents driven onto I/O pins; 8'hFF when not driving (stands in for Z).
REQ-011 io_oe  output  1  high while io_out is actively driven.
REQ-012 q0, q7  output  1 each  serial outputs Q0' (pin 8), Q7' (pin 17).

Function
REQ-013 Block SHALL hold an 8-bit register r and a 1-bit cp_prev, both clk-domain.
REQ-014 cp_prev SHALL load cp every clk edge; chip edge "cpe" = cp & ~cp_prev (combinational).
REQ-015 If n_mr=0 at a clk edge, r SHALL load 8'h00 regardless of cp, s0, s1; cpe ignored.
REQ-016 Else if cpe=1, r SHALL update per mode on that same clk edge; else r holds.
REQ-017 Mode s1,s0=00: hold, r unchanged.
REQ-018 Mode 01 (shift right): r <= {r[6:0], ds0}; bit 0 receives ds0, bit 7 discarded.
REQ-019 Mode 10 (shift left): r <= {ds7, r[7:1]}; bit 7 receives ds7, bit 0 discarded.
REQ-020 Mode 11 (parallel load): r <= io_in.
REQ-021 Mode and serial/parallel data SHALL be sampled on the same clk edge that detects cpe.
REQ-022 Latency: io_out, q0, q7 SHALL show the updated r one clk after the detecting edge (registered r, combinational output).
REQ-023 io_oe SHALL be (~n_oe1 & ~n_oe2 & ~(s0 & s1)), combinational; parallel-load mode always releases the bus.
REQ-024 io_out SHALL equal r when io_oe=1, else 8'hFF.
REQ-025 q0 = r[0], q7 = r[7] at all times, independent of enables and mode.
REQ-026 A cp held high SHALL produce exactly one update; a cp pulse shorter than one clk period may be missed (documented, not an error).
REQ-027 n_mr=0 coincident with cpe: clear wins; no shift/load that edge.
REQ-028 n_mr returning high coincident with cpe: that cpe SHALL be acted on normally.
REQ-029 Mode change between cp edges SHALL have no effect on r; only io_oe changes.

Reset
REQ-030 On reset=1, asynchronously: r <= 8'h00, cp_prev <= 1 (a cp already high at release creates no edge).
REQ-031 While reset=1, cpe and n_mr SHALL be ignored; outputs follow cleared r (io_out = 8'h00 if enabled, q0=q7=0).
REQ-032 Reset asserted mid-operation SHALL discard any pending update; first update after release requires a fresh cp low-to-high.

Verification
REQ-033 Load: s1,s0=11, io_in=8'hA5, cp 0->1 -> next clk r=8'hA5, io_oe=0, io_out=8'hFF; then s=00, n_oe1=n_oe2=0 -> io_out=8'hA5, io_oe=1.
REQ-034 Shift right: r=8'h81, s=01, ds0=0, one cp rise -> r=8'h02, q7=0, q0=0; second rise with ds0=1 -> r=8'h05.
REQ-035 Shift left: r=8'h81, s=10, ds7=1, one cp rise -> r=8'hC0, q0=0, q7=1.
REQ-036 Clear priority: r=8'hFF, n_mr=0 with cp rise, s=11, io_in=8'h3C -> r=8'h00; cp held high 10 clks after n_mr release -> r stays 8'h00.
REQ-037 Enables: r=8'h5A, s=00, each of n_oe1/n_oe2 toggled alone -> io_out=8'hFF, io_oe=0 whenever either is high; q0=0, q7=0 throughout.
REQ-038 Reset: cp=1, r=8'h77, pulse reset -> r=8'h00 asynchronously; cp held high after release -> no update until cp falls and rises again.
